// File: rtl/booth_pkg.sv
// Shared types and helpers for the round-robin Booth multiplier arbiter.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_N_REQ = 4;

    // Next requester index in round-robin order, wrapping at n_req.
    function automatic int next_rr_idx(input int idx, input int n_req);
        return (idx + 1 >= n_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth datapath: A/Q/Q_-1/M registers, one iteration per step.
module booth_seq_core
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product
);

    // A carries one guard bit so that subtracting the most negative M cannot overflow.
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             q_m1;

    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b10:   sum = acc - m_ext;
            2'b01:   sum = acc + m_ext;
            default: sum = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            m    <= '0;
        end else if (load) begin
            acc  <= '0;
            q    <= multiplier;
            q_m1 <= 1'b0;
            m    <= multiplicand;
        end else if (step) begin
            acc  <= {sum[WIDTH], sum[WIDTH:1]};
            q    <= {sum[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
        end
    end

    assign product = {acc[WIDTH-1:0], q};

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier between N_REQ clients.
// Optional macro BOOTH_ARB_ZERO_BYPASS_EN: zero operands skip RUN and respond after one cycle.
module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] multiplier_i,
    input  logic [N_REQ*WIDTH-1:0] multiplicand_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [2*WIDTH-1:0]     result_o,
    output logic                   busy_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           next_state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] count;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    int               idx;
    logic [WIDTH-1:0] sel_mplier;
    logic [WIDTH-1:0] sel_mcand;
    logic [WIDTH-1:0] core_mplier;
    logic             zero_hit;
    logic             handshake;
    logic             load;
    logic             step;

    // Search starts one past the last winner, so the previous winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = int'(ptr);
        for (int k = 0; k < N_REQ; k++) begin
            idx = next_rr_idx(idx, N_REQ);
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign sel_mplier = multiplier_i[grant_id*WIDTH +: WIDTH];
    assign sel_mcand  = multiplicand_i[grant_id*WIDTH +: WIDTH];

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    assign zero_hit = (sel_mplier == '0) || (sel_mcand == '0);
`else
    assign zero_hit = 1'b0;
`endif

    // A bypassed request loads Q=0 so the untouched datapath already reads as product 0.
    assign core_mplier = zero_hit ? '0 : sel_mplier;

    always_comb begin
        next_state  = state;
        handshake   = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        req_ready_o = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready_o[grant_id] = 1'b1;
                    handshake             = 1'b1;
                    load                  = 1'b1;
                    next_state            = zero_hit ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CNT_W'(WIDTH - 1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= ID_W'(N_REQ - 1);
            id_q  <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            if (handshake) begin
                ptr   <= grant_id;
                id_q  <= grant_id;
                count <= '0;
            end else if (step) begin
                count <= count + 1'b1;
            end
        end
    end

    booth_seq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .multiplier  (core_mplier),
        .multiplicand(sel_mcand),
        .product     (result_o)
    );

    assign rsp_valid_o = (state == DONE);
    assign rsp_id_o    = id_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter against a transaction-level reference model.
// Honours BOOTH_ARB_ZERO_BYPASS_EN to predict the shortened zero-operand latency.
module tb_booth_mult_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   multiplier;
    logic [N*W-1:0]   multiplicand;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [2*W-1:0]   result;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: arbiter as a transaction, product as plain signed arithmetic.
    int         m_ptr;
    bit         m_pending;
    int         m_wait;
    int         m_id;
    logic [7:0] m_prod;
    int         last_grant;

    always #5 clk = ~clk;

    booth_mult_arbiter #(
        .N_REQ(N),
        .WIDTH(W),
        .ID_W (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .multiplier_i  (multiplier),
        .multiplicand_i(multiplicand),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .result_o      (result),
        .busy_o        (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sval(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Check one cycle against the model, advance the model, then move to the next negedge.
    task automatic applyStimulus();
        int         exp_grant;
        int         i;
        int         a;
        int         b;
        logic [N-1:0] exp_ready;
        #1;
        last_grant = -1;
        if (!rst) begin
            exp_grant = -1;
            exp_ready = '0;
            if (!m_pending) begin
                for (int k = 1; k <= N; k++) begin
                    i = (m_ptr + k) % N;
                    if (exp_grant < 0 && req_valid[i]) exp_grant = i;
                end
            end
            if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("busy", 32'(busy), 32'(m_pending));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_pending && m_wait == 0));
            if (m_pending && m_wait == 0) begin
                checkOutput("result", 32'(result), 32'(m_prod));
                checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
            end
            if (exp_grant >= 0) begin
                a          = sval(multiplier[exp_grant*W +: W]);
                b          = sval(multiplicand[exp_grant*W +: W]);
                m_prod     = 8'(a * b);
                m_id       = exp_grant;
                m_ptr      = exp_grant;
                m_pending  = 1'b1;
                m_wait     = (BYPASS && (a == 0 || b == 0)) ? 0 : W;
                last_grant = exp_grant;
            end else if (m_pending && m_wait > 0) begin
                m_wait--;
            end else if (m_pending && rsp_ready) begin
                m_pending = 1'b0;
            end
        end else begin
            m_pending = 1'b0;
            m_ptr     = N - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    // Single directed request: checks grant, latency from handshake and the constant product.
    task automatic runOne(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [7:0] exp_prod);
        int n;
        int exp_lat;
        multiplier[id*W +: W]   = a;
        multiplicand[id*W +: W] = b;
        req_valid               = '0;
        req_valid[id]           = 1'b1;
        n = 0;
        applyStimulus();
        while (last_grant != id && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("directed_grant", 32'(last_grant), 32'(id));
        req_valid = '0;
        exp_lat   = (BYPASS && (a == '0 || b == '0)) ? 1 : W + 1;
        n = 1;
        while (!rsp_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("latency", 32'(n), 32'(exp_lat));
        checkOutput("directed_product", 32'(result), 32'(exp_prod));
        checkOutput("directed_id", 32'(rsp_id), 32'(id));
        applyStimulus();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants[$];
        int n;
        int chosen;
        logic [7:0] pair;

        rst          = 1'b1;
        req_valid    = '0;
        multiplier   = '0;
        multiplicand = '0;
        rsp_ready    = 1'b1;
        m_ptr        = N - 1;
        m_pending    = 1'b0;
        m_wait       = 0;
        m_id         = 0;
        m_prod       = '0;
        last_grant   = -1;
        @(negedge clk);
        applyStimulus();
        doReset();

        checkOutput("reset_result", 32'(result), 32'h0);
        checkOutput("reset_id", 32'(rsp_id), 32'h0);
        checkOutput("reset_valid", 32'(rsp_valid), 32'h0);
        applyStimulus();

        runOne(0, 4'd3, 4'hE, 8'hFA);
        runOne(1, 4'h8, 4'h8, 8'h40);
        runOne(2, 4'd7, 4'h8, 8'hC8);
        runOne(3, 4'd0, 4'd5, 8'h00);
        runOne(0, 4'hF, 4'hF, 8'h01);

        // All requesters valid: fair rotation from requester 0 after reset.
        doReset();
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            multiplier   = 16'($urandom);
            multiplicand = 16'($urandom);
            applyStimulus();
            if (last_grant >= 0) grants.push_back(last_grant);
        end
        checkOutput("rr_count", 32'(grants.size() >= 5), 32'h1);
        if (grants.size() >= 5) begin
            for (int g = 0; g < 5; g++) checkOutput("rr_order", 32'(grants[g]), 32'(g % N));
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) applyStimulus();

        // Backpressure: the model checks that DONE outputs hold and no grant appears.
        rsp_ready = 1'b0;
        req_valid = '0;
        multiplier[2*W +: W]   = 4'h5;
        multiplicand[2*W +: W] = 4'hA;
        req_valid[2] = 1'b1;
        applyStimulus();
        req_valid = '1;
        for (int c = 0; c < W + 12; c++) applyStimulus();
        rsp_ready = 1'b1;
        req_valid = '0;
        applyStimulus();
        checkOutput("bp_release_idle", 32'(busy), 32'h0);
        applyStimulus();

        // Reset two cycles into RUN must abort without a response.
        req_valid    = '0;
        req_valid[1] = 1'b1;
        multiplier[1*W +: W]   = 4'd6;
        multiplicand[1*W +: W] = 4'd3;
        n = 0;
        applyStimulus();
        while (last_grant != 1 && n < 20) begin
            applyStimulus();
            n++;
        end
        req_valid = '0;
        applyStimulus();
        applyStimulus();
        doReset();
        for (int c = 0; c < W + 3; c++) applyStimulus();
        req_valid = 4'b0101;
        applyStimulus();
        checkOutput("post_reset_winner", 32'(last_grant), 32'h0);
        req_valid = '0;
        for (int c = 0; c < W + 3; c++) applyStimulus();

        // All 256 operand pairs, each issued by a random requester amid random traffic.
        for (int p = 0; p < 256; p++) begin
            pair   = 8'(p);
            chosen = int'($urandom_range(0, N - 1));
            n = 0;
            do begin
                for (int j = 0; j < N; j++) begin
                    if (j != chosen) begin
                        req_valid[j]            = 1'($urandom);
                        multiplier[j*W +: W]    = 4'($urandom);
                        multiplicand[j*W +: W]  = 4'($urandom);
                    end
                end
                req_valid[chosen]            = 1'b1;
                multiplier[chosen*W +: W]    = pair[7:4];
                multiplicand[chosen*W +: W]  = pair[3:0];
                rsp_ready = ($urandom_range(0, 3) != 0);
                applyStimulus();
                n++;
            end while (last_grant != chosen && n < 80);
            if (last_grant != chosen) checkOutput("sweep_grant_timeout", 32'(last_grant), 32'(chosen));
            req_valid[chosen] = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2 * W + 4; c++) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential radix-2 Booth multiplier between N_REQ requesters.
- Accepts one signed multiply request at a time and runs the Booth iterations, one per clock.
- Returns the 2*WIDTH-bit product, tagged with the requester ID, over a valid/ready response channel.
- Sits between several client datapaths and the single multiplier resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits (signed two's complement).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
- multiplier_i  in  N_REQ*WIDTH  packed multipliers; requester i in slice [i*WIDTH +: WIDTH].
- multiplicand_i  in  N_REQ*WIDTH  packed multiplicands, same packing.
- rsp_valid_o  out  1  product valid.
- rsp_ready_i  in  1  consumer accepts product.
- rsp_id_o  out  ID_W  index of the requester that owns the product.
- result_o  out  2*WIDTH  signed product.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; rsp_valid_o=0; rsp_id_o=0; result_o=0; busy_o=0; req_ready_o=0 in the cycle after reset.
  - RR pointer=N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation aborts the operation: no response is issued and the operands are discarded.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - Grant is combinational. Search starts at pointer+1 and wraps modulo N_REQ. The first i with req_valid_i[i]=1 gets req_ready_o[i]=1; all other bits are 0.
  - Handshake happens when valid&ready are both high at a clock edge. On the handshake:
    - Load A=0, Q=multiplier, Q_-1=0, M=multiplicand, count=0.
    - Latch the granted ID and set pointer=granted ID.
    - Go to RUN.
  - No valid requests: stay in IDLE, req_ready_o=0.
- RUN: exactly WIDTH cycles, one Booth iteration per cycle.
  - {Q0,Q_-1}=10: A=A-M.
  - {Q0,Q_-1}=01: A=A+M.
  - 00 or 11: A unchanged.
  - Then arithmetic-shift right {A,Q,Q_-1} by one, combined in the same cycle.
  - A is WIDTH+1 bits internally, sign-extended, so M=-2^(WIDTH-1) does not overflow.
  - When count reaches WIDTH-1 the iteration completes; next state is DONE.
- DONE:
  - rsp_valid_o=1, result_o={A[WIDTH-1:0],Q}, rsp_id_o=latched ID.
  - Outputs hold stable until rsp_ready_i=1 at a clock edge, then state=IDLE and rsp_valid_o=0.
  - req_ready_o is 0 throughout RUN and DONE.
- Latency: handshake edge to first rsp_valid_o=1 is WIDTH+1 cycles.
- Throughput: one product per WIDTH+2 cycles with rsp_ready_i tied high. No new grant in the same cycle as the response handshake.
- Request inputs are sampled only on the handshake edge; changes during RUN have no effect.
- A requester whose req_valid_i drops before it is granted is simply skipped.
- Result range: -2^(WIDTH-1) squared = 2^(2WIDTH-2) fits the signed 2*WIDTH output. No saturation.

Optional Feature:
- Macro: BOOTH_ARB_ZERO_BYPASS_EN.
- Defined: if either granted operand is 0 at the handshake, skip RUN.
  - Next state is DONE with result 0, so latency is 1 cycle.
  - Pointer, ID and handshake rules are unchanged.
- Undefined: every request takes the full WIDTH+1 latency, including zero operands.

Decomposition:
- Package booth_pkg holds:
  - State enum: IDLE, RUN, DONE.
  - Default WIDTH and N_REQ constants.
  - A function for the next round-robin index.
- Sub-module booth_seq_core holds the A/Q/Q_-1/M registers and the iteration step. It has inputs load, step, operands and outputs product.
- booth_mult_arbiter keeps the FSM, the iteration counter, the RR pointer, the grant logic and the response registers.

Test Plan:
- Single requester: req 0 with multiplier=3, multiplicand=-2, rsp_ready tied 1 -> rsp_valid at handshake+5 cycles, result=0xFA (-6), id=0.
- Corner operands: -8*-8 -> 0x40 (64); 7*-8 -> 0xC8 (-56); 0*5 -> 0x00 at handshake+5 without the macro and at handshake+1 with BOOTH_ARB_ZERO_BYPASS_EN.
- All 4 requesters valid continuously -> grants in order 0,1,2,3,0. Only one req_ready bit high per grant. Each id pairs with its own product.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> result, id and rsp_valid stable; no req_ready asserted; release -> IDLE next cycle.
- Reset mid-RUN: rst=1 two cycles after a handshake -> no rsp_valid. After reset, requester 0 wins when requesters 0 and 2 are both valid.
- Exhaustive sweep: all 256 operand pairs from random requesters -> product matches a signed reference model.
